// File: rtl/qsys_pio_pkg.sv
// Shared register map, edge encodings and counter sizing for the Qsys PIO family.
package qsys_pio_pkg;

  typedef enum logic [1:0] {
    ADDR_DATA = 2'd0,
    ADDR_RAW  = 2'd1,
    ADDR_MASK = 2'd2,
    ADDR_EDGE = 2'd3
  } pio_addr_e;

  localparam int EDGE_RISING  = 0;
  localparam int EDGE_FALLING = 1;
  localparam int EDGE_ANY     = 2;

  // One extra bit keeps the terminal count representable for powers of two.
  function automatic int cnt_width(input int cycles);
    return $clog2(cycles) + 1;
  endfunction

endpackage

// File: rtl/switch_debounce_bit.sv
// One switch bit: SYNC_STAGES-deep synchroniser followed by a stability filter.
// With SWITCH_DEBOUNCE_EN undefined the filter collapses to a single flop.
module switch_debounce_bit
  import qsys_pio_pkg::*;
#(
  parameter int SYNC_STAGES     = 2,
  parameter int DEBOUNCE_CYCLES = 50000
) (
  input  logic clk,
  input  logic reset,
  input  logic d_i,
  output logic sync_o,
  output logic stable_o
);

  if (SYNC_STAGES < 2 || DEBOUNCE_CYCLES < 2) begin : g_bad_param
    $error("switch_debounce_bit: SYNC_STAGES and DEBOUNCE_CYCLES must be >= 2");
  end

  logic [SYNC_STAGES-1:0] sync_q;
  logic                   stable_q;

  always_ff @(posedge clk) begin
    if (reset) sync_q <= '0;
    else       sync_q <= {sync_q[SYNC_STAGES-2:0], d_i};
  end

  assign sync_o = sync_q[SYNC_STAGES-1];

`ifdef SWITCH_DEBOUNCE_EN
  localparam int             CW      = cnt_width(DEBOUNCE_CYCLES);
  localparam logic [CW-1:0]  CNT_MAX = CW'(DEBOUNCE_CYCLES - 1);

  logic [CW-1:0] cnt_q;

  // Any sample matching the accepted level restarts qualification.
  always_ff @(posedge clk) begin
    if (reset) begin
      cnt_q    <= '0;
      stable_q <= 1'b0;
    end else if (sync_o == stable_q) begin
      cnt_q    <= '0;
    end else if (cnt_q == CNT_MAX) begin
      stable_q <= sync_o;
      cnt_q    <= '0;
    end else begin
      cnt_q    <= cnt_q + 1'b1;
    end
  end
`else
  always_ff @(posedge clk) begin
    if (reset) stable_q <= 1'b0;
    else       stable_q <= sync_o;
  end
`endif

  assign stable_o = stable_q;

endmodule

// File: rtl/qsys_switch_irq.sv
// Avalon-MM switch/button PIO with debounce, edge capture (W1C), irq mask and irq.
// Debounce counters are built only when SWITCH_DEBOUNCE_EN is defined.
module qsys_switch_irq
  import qsys_pio_pkg::*;
#(
  parameter int WIDTH           = 6,
  parameter int SYNC_STAGES     = 2,
  parameter int DEBOUNCE_CYCLES = 50000,
  parameter int EDGE_TYPE       = 0
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [1:0]       address,
  input  logic             write,
  input  logic [31:0]      writedata,
  output logic [31:0]      readdata,
  input  logic [WIDTH-1:0] in_port,
  output logic             irq
);

  logic [WIDTH-1:0] sync, stable, edge_ev;
  logic [WIDTH-1:0] prev_q, mask_q, mask_d, cap_q, cap_d;
  logic [31:0]      rdata_q, rdata_d;
  logic             irq_q;
  logic             unused_wdata;

  for (genvar i = 0; i < WIDTH; i++) begin : g_bit
    switch_debounce_bit #(
      .SYNC_STAGES    (SYNC_STAGES),
      .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
    ) u_bit (
      .clk     (clk),
      .reset   (reset),
      .d_i     (in_port[i]),
      .sync_o  (sync[i]),
      .stable_o(stable[i])
    );
  end

  always_comb begin
    if (EDGE_TYPE == EDGE_FALLING)  edge_ev = ~stable & prev_q;
    else if (EDGE_TYPE == EDGE_ANY) edge_ev = stable ^ prev_q;
    else                            edge_ev = stable & ~prev_q;
  end

  always_comb begin
    mask_d = mask_q;
    cap_d  = cap_q;
    if (write && pio_addr_e'(address) == ADDR_MASK) mask_d = writedata[WIDTH-1:0];
    if (write && pio_addr_e'(address) == ADDR_EDGE) cap_d  = cap_q & ~writedata[WIDTH-1:0];
    // Set after clear so a coincident edge survives the W1C.
    cap_d = cap_d | edge_ev;
  end

  always_comb begin
    rdata_d = '0;
    case (pio_addr_e'(address))
      ADDR_DATA: rdata_d = 32'(stable);
      ADDR_RAW:  rdata_d = 32'(sync);
      ADDR_MASK: rdata_d = 32'(mask_q);
      ADDR_EDGE: rdata_d = 32'(cap_q);
      default:   rdata_d = '0;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      prev_q  <= '0;
      mask_q  <= '0;
      cap_q   <= '0;
      rdata_q <= '0;
      irq_q   <= 1'b0;
    end else begin
      prev_q  <= stable;
      mask_q  <= mask_d;
      cap_q   <= cap_d;
      rdata_q <= rdata_d;
      irq_q   <= |(cap_q & mask_q);
    end
  end

  assign readdata     = rdata_q;
  assign irq          = irq_q;
  assign unused_wdata = ^writedata;

endmodule
